imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Inverse of the immediate generator. Takes an encoding type, register/function fields and a 32-bit signed immediate, then packs them into a 32-bit RV32I instruction word.
Used by the boot/debug instruction injector and by the self-check bench model, which need legal instruction words built in hardware.
Two-stage valid/ready pipeline. Stage 1 registers the operands and does the range check; stage 2 packs the instruction and presents it.
Keeps a saturating count of immediates that could not be encoded.

Parameters:
ERR_CNT_WIDTH, 16, width of the saturating range-error counter.
STRICT, 1, 1 = discard out-of-range requests (no output beat); 0 = emit the packed word with out_range_err=1.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  encoder can accept a request this cycle.
in_encoding  input  encoding_type  R/I/S/B/U/J from the common package.
in_opcode  input  7  opcode field, inst[6:0].
in_rd  input  5  inst[11:7] for R/I/U/J.
in_funct3  input  3  inst[14:12] for R/I/S/B.
in_rs1  input  5  inst[19:15] for R/I/S/B.
in_rs2  input  5  inst[24:20] for R/S/B.
in_funct7  input  7  inst[31:25] for R only.
in_imm  input  32  immediate, two's complement byte value as imm_gen would return it.
out_valid  output  1  packed instruction valid.
out_ready  input  1  consumer accepts.
out_instruction  output  instruction_type  packed 32-bit word.
out_range_err  output  1  immediate of this beat was not representable (only when STRICT=0).
clear_err  input  1  synchronous clear of err_count.
err_count  output  ERR_CNT_WIDTH  saturating count of range errors.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Both stage valid bits clear.
  - out_valid=0, out_instruction=0, out_range_err=0, err_count=0.
  - in_ready=1 once reset is released.
  - Reset mid-transfer drops all in-flight requests.
- Handshake:
  - Transfer occurs on a cycle where valid&ready are both high.
  - in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready | (s1 is a STRICT discard).
  - out_* stay stable while out_valid=1 and out_ready=0.
  - Full throughput: one beat per cycle with out_ready held high.
- Latency: an accepted request appears on out_instruction 2 cycles after acceptance when there is no backpressure.
- Stage 1 range check on the registered in_imm:
  - I, S: value must be in -2048..2047.
  - B: value must be in -4096..4094 and imm[0]=0.
  - J: value must be in -1048576..1048574 and imm[0]=0.
  - U: imm[11:0] must be 0.
  - R: in_imm is ignored; never an error.
- Stage 2 packing (opcode always in [6:0]):
  - R: funct7, rs2, rs1, funct3, rd.
  - I: imm[11:0] in [31:20], rs1, funct3, rd.
  - S: imm[11:5] in [31:25], rs2, rs1, funct3, imm[4:0] in [11:7].
  - B: imm[12] in [31], imm[10:5] in [30:25], rs2, rs1, funct3, imm[4:1] in [11:8], imm[11] in [7].
  - U: imm[31:12] in [31:12], rd.
  - J: imm[20] in [31], imm[10:1] in [30:21], imm[11] in [20], imm[19:12] in [19:12], rd.
  - Fields the encoding does not use: the input is ignored.
  - Out-of-range value with STRICT=0: the low bits are packed anyway (truncation).
- Error counting:
  - err_count increments by 1 when an erroneous request leaves stage 1 (discarded or moved to stage 2). Exactly once per request, never repeated during stalls.
  - Saturates at all-ones.
  - clear_err has priority over a same-cycle increment: the result is 0.
- Discard case (STRICT=1, erroneous entry): the entry is removed from stage 1 in one cycle regardless of out_ready, and produces no out_valid beat.
- Simultaneous events: accept into stage 1 and advance into stage 2 in the same cycle are allowed; no bubble.
- Unknown encoding value: treat as R-type.

Test Plan:
- I-type, opcode=0x13, rd=1, funct3=0, rs1=0, imm=0xFFFFFFFF (addi x1,x0,-1) -> out_instruction=0xFFF00093 two cycles after accept, out_range_err=0.
- S-type, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 (sw x2,8(x1)) -> 0x0020A423.
- B-type, opcode=0x63, rs1=0, rs2=0, funct3=0, imm=0xFFFFFFFC (beq -4) -> 0xFE000EE3.
- U-type, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7. The same request with imm=0x12345001 -> STRICT=1: no beat and err_count 0->1; STRICT=0: 0x123452B7 with out_range_err=1.
- Backpressure: 4 back-to-back I-type requests with out_ready low for 3 cycles -> in_ready falls after 2 accepts; outputs stay stable while stalled; all 4 words emitted in order once out_ready returns; err_count unchanged.
- Counter: ERR_CNT_WIDTH=2, 5 I-type requests with imm=2048 -> err_count saturates at 3. clear_err in the same cycle as a 6th error -> err_count=0. reset_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: inverse of the immediate generator. Packs an encoding type,
// register/function fields and a 32-bit signed immediate into an RV32I
// instruction word through a two-stage valid/ready pipeline. Stage 1 holds
// the operands and flags immediates the chosen format cannot represent;
// stage 2 holds the packed word presented to the consumer.

package imm_encoder_pkg;
   typedef enum logic [2:0] {
      ENC_R = 3'd0,
      ENC_I = 3'd1,
      ENC_S = 3'd2,
      ENC_B = 3'd3,
      ENC_U = 3'd4,
      ENC_J = 3'd5
   } encoding_type;

   typedef logic [31:0] instruction_type;
endpackage

module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int ERR_CNT_WIDTH = 16,
   parameter bit STRICT        = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  encoding_type             in_encoding,
   input  logic [6:0]               in_opcode,
   input  logic [4:0]               in_rd,
   input  logic [2:0]               in_funct3,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [6:0]               in_funct7,
   input  logic [31:0]              in_imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output instruction_type          out_instruction,
   output logic                     out_range_err,
   input  logic                     clear_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam logic STRICT_MODE = STRICT;

   // True when the immediate cannot be represented by the given format.
   // Signed ranges are checked as "all bits above the field are copies of
   // the sign bit"; B and J additionally need an even offset.
   function automatic logic imm_out_of_range(input encoding_type enc,
                                             input logic [31:0]  imm);
      logic err;
      case (enc)
         ENC_I, ENC_S: err = (imm[31:11] != 21'h000000) && (imm[31:11] != 21'h1FFFFF);
         ENC_B:        err = ((imm[31:12] != 20'h00000) && (imm[31:12] != 20'hFFFFF)) || imm[0];
         ENC_J:        err = ((imm[31:20] != 12'h000) && (imm[31:20] != 12'hFFF)) || imm[0];
         ENC_U:        err = (imm[11:0] != 12'h000);
         default:      err = 1'b0;
      endcase
      return err;
   endfunction

   // Scatter the fields into the RV32I layout of the given format. Bits of
   // an out-of-range immediate above the field are simply dropped.
   function automatic instruction_type pack_word(input encoding_type enc,
                                                 input logic [6:0]   opcode,
                                                 input logic [4:0]   rd,
                                                 input logic [2:0]   funct3,
                                                 input logic [4:0]   rs1,
                                                 input logic [4:0]   rs2,
                                                 input logic [6:0]   funct7,
                                                 input logic [31:0]  imm);
      instruction_type word;
      case (enc)
         ENC_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
         ENC_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         ENC_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         ENC_U:   word = {imm[31:12], rd, opcode};
         ENC_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: word = {funct7, rs2, rs1, funct3, rd, opcode};
      endcase
      return word;
   endfunction

   // Stage 1 state
   logic                     s1_valid_r;
   encoding_type             s1_enc_r;
   logic [6:0]               s1_opcode_r;
   logic [4:0]               s1_rd_r;
   logic [2:0]               s1_funct3_r;
   logic [4:0]               s1_rs1_r;
   logic [4:0]               s1_rs2_r;
   logic [6:0]               s1_funct7_r;
   logic [31:0]              s1_imm_r;

   // Stage 2 state (drives the outputs directly)
   logic                     out_valid_r;
   instruction_type          out_instruction_r;
   logic                     out_range_err_r;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

   // Handshake and control
   logic                     s1_err_s;
   logic                     s1_discard_s;
   logic                     s1_advance_s;
   logic                     s1_leave_s;
   logic                     s2_load_s;
   logic                     in_ready_s;
   logic                     accept_s;

   // Range check on the held operands and the pipeline advance conditions.
   always_comb begin
      s1_err_s = 1'b0;
      if (s1_valid_r) begin
         s1_err_s = imm_out_of_range(s1_enc_r, s1_imm_r);
      end else begin
         s1_err_s = 1'b0;
      end
      // A strict-mode error is dropped in place, so it never waits on stage 2.
      s1_discard_s = s1_valid_r & s1_err_s & STRICT_MODE;
      s1_advance_s = ~out_valid_r | out_ready | s1_discard_s;
      s1_leave_s   = s1_valid_r & s1_advance_s;
      s2_load_s    = s1_leave_s & ~s1_discard_s;
      in_ready_s   = ~s1_valid_r | s1_advance_s;
      accept_s     = in_valid & in_ready_s;
   end

   // Stage 1 register: capture a request on accept, empty when it leaves.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_r  <= 1'b0;
         s1_enc_r    <= ENC_R;
         s1_opcode_r <= 7'd0;
         s1_rd_r     <= 5'd0;
         s1_funct3_r <= 3'd0;
         s1_rs1_r    <= 5'd0;
         s1_rs2_r    <= 5'd0;
         s1_funct7_r <= 7'd0;
         s1_imm_r    <= 32'd0;
      end else if (accept_s) begin
         s1_valid_r  <= 1'b1;
         s1_enc_r    <= in_encoding;
         s1_opcode_r <= in_opcode;
         s1_rd_r     <= in_rd;
         s1_funct3_r <= in_funct3;
         s1_rs1_r    <= in_rs1;
         s1_rs2_r    <= in_rs2;
         s1_funct7_r <= in_funct7;
         s1_imm_r    <= in_imm;
      end else if (s1_leave_s) begin
         s1_valid_r  <= 1'b0;
      end
   end

   // Stage 2 register: load the packed word, hold it until the consumer takes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_r       <= 1'b0;
         out_instruction_r <= 32'd0;
         out_range_err_r   <= 1'b0;
      end else if (s2_load_s) begin
         out_valid_r       <= 1'b1;
         out_instruction_r <= pack_word(s1_enc_r, s1_opcode_r, s1_rd_r, s1_funct3_r,
                                        s1_rs1_r, s1_rs2_r, s1_funct7_r, s1_imm_r);
         out_range_err_r   <= s1_err_s;
      end else if (out_ready) begin
         out_valid_r       <= 1'b0;
      end
   end

   // Saturating error counter: one count per erroneous request as it leaves
   // stage 1; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_r <= '0;
      end else if (clear_err) begin
         err_cnt_r <= '0;
      end else if (s1_leave_s && s1_err_s && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
         err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
      end
   end

   assign in_ready        = in_ready_s;
   assign out_valid       = out_valid_r;
   assign out_instruction = out_instruction_r;
   assign out_range_err   = out_range_err_r;
   assign err_count       = err_cnt_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder. Two instances: "a" is STRICT=1 with a 2-bit error
// counter, "b" is STRICT=0 with a 16-bit counter. One driver is steered to
// the selected instance; the other drains freely and sees no requests.
module tb_imm_encoder;
   import imm_encoder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n;
   logic            sel;
   logic            in_valid;
   logic            out_ready;
   logic            clear_err;
   encoding_type    in_encoding;
   logic [6:0]      in_opcode;
   logic [4:0]      in_rd;
   logic [2:0]      in_funct3;
   logic [4:0]      in_rs1;
   logic [4:0]      in_rs2;
   logic [6:0]      in_funct7;
   logic [31:0]     in_imm;

   logic            in_ready_a, out_valid_a, out_range_err_a;
   instruction_type out_instruction_a;
   logic [1:0]      err_count_a;
   logic            in_ready_b, out_valid_b, out_range_err_b;
   instruction_type out_instruction_b;
   logic [15:0]     err_count_b;

   wire in_valid_a  = in_valid & ~sel;
   wire in_valid_b  = in_valid & sel;
   wire out_ready_a = sel ? 1'b1 : out_ready;
   wire out_ready_b = sel ? out_ready : 1'b1;
   wire clear_err_a = clear_err & ~sel;
   wire clear_err_b = clear_err & sel;

   wire             in_ready_m        = sel ? in_ready_b : in_ready_a;
   wire             out_valid_m       = sel ? out_valid_b : out_valid_a;
   wire [31:0]      out_instruction_m = sel ? out_instruction_b : out_instruction_a;
   wire             out_range_err_m   = sel ? out_range_err_b : out_range_err_a;
   wire [15:0]      err_count_m       = sel ? err_count_b : {14'd0, err_count_a};

   imm_encoder #(.ERR_CNT_WIDTH(2), .STRICT(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_encoding(in_encoding), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_instruction(out_instruction_a), .out_range_err(out_range_err_a),
      .clear_err(clear_err_a), .err_count(err_count_a)
   );

   imm_encoder #(.ERR_CNT_WIDTH(16), .STRICT(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_encoding(in_encoding), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_instruction(out_instruction_b), .out_range_err(out_range_err_b),
      .clear_err(clear_err_b), .err_count(err_count_b)
   );

   int total = 0;
   int bad   = 0;
   int exp_cnt_a = 0;
   int exp_cnt_b = 0;

   logic [32:0] cap_q[$];
   logic [32:0] exp_q[$];

   typedef struct packed {
      encoding_type enc;
      logic [6:0]   op;
      logic [4:0]   rd;
      logic [2:0]   f3;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [6:0]   f7;
      logic [31:0]  imm;
      logic [31:0]  word;
      logic         err;
   } vec_t;

   typedef struct packed {
      encoding_type enc;
      logic [31:0]  imm;
      logic         err;
   } bnd_t;

   // Record every beat the selected instance hands over.
   always @(negedge clk) begin
      if (reset_n && out_valid_m && out_ready) cap_q.push_back({out_range_err_m, out_instruction_m});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Representability from the numeric ranges of each format.
   function automatic logic ref_err(input encoding_type e, input logic [31:0] imm);
      int v;
      v = $signed(imm);
      case (e)
         ENC_I, ENC_S: return (v < -2048) || (v > 2047);
         ENC_B:        return (v < -4096) || (v > 4094) || ((v % 2) != 0);
         ENC_J:        return (v < -1048576) || (v > 1048574) || ((v % 2) != 0);
         ENC_U:        return (imm % 32'd4096) != 32'd0;
         default:      return 1'b0;
      endcase
   endfunction

   // Instruction word built by shifting and masking each field into place.
   function automatic logic [31:0] ref_word(input encoding_type e, input logic [6:0] op,
                                            input logic [4:0] rd, input logic [2:0] f3,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [6:0] f7, input logic [31:0] imm);
      logic [31:0] w;
      logic [31:0] r_rd, r_f3, r_rs1, r_rs2, r_f7;
      r_rd = 32'(rd) << 7;  r_f3 = 32'(f3) << 12; r_rs1 = 32'(rs1) << 15;
      r_rs2 = 32'(rs2) << 20; r_f7 = 32'(f7) << 25;
      w = 32'(op);
      case (e)
         ENC_I: w = w | ((imm & 32'hFFF) << 20) | r_rs1 | r_f3 | r_rd;
         ENC_S: w = w | (((imm >> 5) & 32'h7F) << 25) | r_rs2 | r_rs1 | r_f3 | ((imm & 32'h1F) << 7);
         ENC_B: w = w | (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r_rs2 | r_rs1
                      | r_f3 | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7);
         ENC_U: w = w | (imm & 32'hFFFFF000) | r_rd;
         ENC_J: w = w | (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | r_rd;
         default: w = w | r_f7 | r_rs2 | r_rs1 | r_f3 | r_rd;
      endcase
      return w;
   endfunction

   task automatic set_fields(input encoding_type e, input logic [6:0] op, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [6:0] f7, input logic [31:0] imm);
      in_encoding = e; in_opcode = op; in_rd = rd; in_funct3 = f3;
      in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
   endtask

   // Present one request and hold it until accepted; returns just after the
   // accepting edge.
   task automatic send(input encoding_type e, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] f7, input logic [31:0] imm);
      logic ok;
      ok = 1'b0;
      set_fields(e, op, rd, f3, rs1, rs2, f7, imm);
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready_m;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL send_timeout in_ready stayed 0 for 50 cycles, want 1");
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
      set_fields(ENC_R, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid_a got %b want 0", out_valid_a); end
      total++; if (out_instruction_a !== 32'd0) begin bad++; $display("FAIL rst_word_a got %h want 0", out_instruction_a); end
      total++; if (out_range_err_a !== 1'b0) begin bad++; $display("FAIL rst_err_a got %b want 0", out_range_err_a); end
      total++; if (err_count_a !== 2'd0) begin bad++; $display("FAIL rst_cnt_a got %0d want 0", err_count_a); end
      total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL rst_valid_b got %b want 0", out_valid_b); end
      total++; if (out_instruction_b !== 32'd0) begin bad++; $display("FAIL rst_word_b got %h want 0", out_instruction_b); end
      total++; if (err_count_b !== 16'd0) begin bad++; $display("FAIL rst_cnt_b got %0d want 0", err_count_b); end
      reset_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_ready_a got %b want 1", in_ready_a); end
      total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL rst_ready_b got %b want 1", in_ready_b); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      vec_t vecs[8];
      logic beat;
      vecs[0] = '{ENC_I, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
      vecs[1] = '{ENC_S, 7'h23, 5'd31, 3'd2, 5'd1,  5'd2,  7'h7F, 32'h00000008, 32'h0020A423, 1'b0};
      vecs[2] = '{ENC_B, 7'h63, 5'd31, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
      vecs[3] = '{ENC_U, 7'h37, 5'd5,  3'd7, 5'd31, 5'd31, 7'h7F, 32'h12345000, 32'h123452B7, 1'b0};
      vecs[4] = '{ENC_U, 7'h37, 5'd5,  3'd7, 5'd31, 5'd31, 7'h7F, 32'h12345001, 32'h123452B7, 1'b1};
      vecs[5] = '{ENC_R, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0};
      vecs[6] = '{ENC_R, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h20, 32'h00000000, 32'h402081B3, 1'b0};
      vecs[7] = '{ENC_J, 7'h6F, 5'd0,  3'd5, 5'd9,  5'd9,  7'h11, 32'hFFFFFFF8, 32'hFF9FF06F, 1'b0};
      out_ready = 1'b1;
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         for (int i = 0; i < 8; i++) begin
            beat = !(vecs[i].err && s == 0);
            send(vecs[i].enc, vecs[i].op, vecs[i].rd, vecs[i].f3, vecs[i].rs1,
                 vecs[i].rs2, vecs[i].f7, vecs[i].imm);
            if (vecs[i].err) begin
               if (s == 0) exp_cnt_a = (exp_cnt_a < 3) ? exp_cnt_a + 1 : 3;
               else        exp_cnt_b = exp_cnt_b + 1;
            end
            @(negedge clk);
            total++;
            if (out_valid_m !== 1'b0) begin
               bad++; $display("FAIL dir%0d_s%0d_early out_valid got %b want 0", i, s, out_valid_m);
            end
            @(negedge clk);
            total++;
            if (out_valid_m !== beat) begin
               bad++; $display("FAIL dir%0d_s%0d_valid got %b want %b", i, s, out_valid_m, beat);
            end
            if (beat) begin
               total++;
               if (out_instruction_m !== vecs[i].word) begin
                  bad++; $display("FAIL dir%0d_s%0d_word got %h want %h", i, s, out_instruction_m, vecs[i].word);
               end
               total++;
               if (out_range_err_m !== vecs[i].err) begin
                  bad++; $display("FAIL dir%0d_s%0d_rerr got %b want %b", i, s, out_range_err_m, vecs[i].err);
               end
            end
            total++;
            if (err_count_m !== 16'((s == 0) ? exp_cnt_a : exp_cnt_b)) begin
               bad++; $display("FAIL dir%0d_s%0d_cnt got %0d want %0d", i, s, err_count_m,
                               (s == 0) ? exp_cnt_a : exp_cnt_b);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_boundaries();
      bnd_t b[19];
      logic [31:0] w;
      b[0]  = '{ENC_I, 32'h000007FF, 1'b0};  // 2047
      b[1]  = '{ENC_I, 32'hFFFFF800, 1'b0};  // -2048
      b[2]  = '{ENC_I, 32'h00000800, 1'b1};  // 2048
      b[3]  = '{ENC_I, 32'hFFFFF7FF, 1'b1};  // -2049
      b[4]  = '{ENC_S, 32'h000007FF, 1'b0};
      b[5]  = '{ENC_S, 32'hFFFFF7FF, 1'b1};
      b[6]  = '{ENC_B, 32'h00000FFE, 1'b0};  // 4094
      b[7]  = '{ENC_B, 32'hFFFFF000, 1'b0};  // -4096
      b[8]  = '{ENC_B, 32'h00001000, 1'b1};  // 4096
      b[9]  = '{ENC_B, 32'h00000003, 1'b1};  // odd
      b[10] = '{ENC_B, 32'hFFFFEFFE, 1'b1};  // -4098
      b[11] = '{ENC_B, 32'hFFFFF001, 1'b1};  // -4095, odd
      b[12] = '{ENC_J, 32'h000FFFFE, 1'b0};  // 1048574
      b[13] = '{ENC_J, 32'hFFF00000, 1'b0};  // -1048576
      b[14] = '{ENC_J, 32'h00100000, 1'b1};  // 1048576
      b[15] = '{ENC_J, 32'h00000001, 1'b1};  // odd
      b[16] = '{ENC_J, 32'hFFEFFFFE, 1'b1};  // -1048578
      b[17] = '{ENC_U, 32'hFFFFF000, 1'b0};
      b[18] = '{ENC_U, 32'h00000800, 1'b1};
      sel = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 19; i++) begin
         send(b[i].enc, 7'h55, 5'd7, 3'd5, 5'd9, 5'd11, 7'h2A, b[i].imm);
         if (b[i].err) exp_cnt_b = exp_cnt_b + 1;
         w = ref_word(b[i].enc, 7'h55, 5'd7, 3'd5, 5'd9, 5'd11, 7'h2A, b[i].imm);
         @(negedge clk);
         @(negedge clk);
         total++;
         if (out_valid_m !== 1'b1 || out_range_err_m !== b[i].err) begin
            bad++; $display("FAIL bnd%0d_flag got valid=%b rerr=%b want valid=1 rerr=%b",
                            i, out_valid_m, out_range_err_m, b[i].err);
         end
         total++;
         if (out_instruction_m !== w) begin
            bad++; $display("FAIL bnd%0d_word got %h want %h", i, out_instruction_m, w);
         end
         @(posedge clk); #1;
      end
      total++;
      if (err_count_b !== 16'(exp_cnt_b)) begin
         bad++; $display("FAIL bnd_cnt got %0d want %0d", err_count_b, exp_cnt_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words[4];
      int idx, first_low, stable_checks;
      logic prev_stalled;
      logic [31:0] prev_word;
      logic done;
      sel = 1'b0; cap_q.delete();
      idx = 0; first_low = -1; prev_stalled = 1'b0; prev_word = 32'd0; done = 1'b0;
      stable_checks = 0;
      for (int i = 0; i < 4; i++)
         words[i] = ref_word(ENC_I, 7'h13, 5'(i + 1), 3'd0, 5'd2, 5'd0, 7'd0, 32'(i * 16) - 32'd20);
      for (int c = 0; c < 40 && !done; c++) begin
         if (idx < 4) begin
            set_fields(ENC_I, 7'h13, 5'(idx + 1), 3'd0, 5'd2, 5'd0, 7'd0, 32'(idx * 16) - 32'd20);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (c >= 5);
         @(negedge clk);
         if (prev_stalled) begin
            stable_checks++;
            total++;
            if (out_valid_m !== 1'b1 || out_instruction_m !== prev_word) begin
               bad++; $display("FAIL b2b_stable c=%0d got valid=%b word=%h want valid=1 word=%h",
                               c, out_valid_m, out_instruction_m, prev_word);
            end
         end
         if (!in_ready_m && first_low < 0) first_low = idx;
         if (in_valid && in_ready_m) idx++;
         prev_stalled = out_valid_m && !out_ready;
         prev_word = out_instruction_m;
         done = (idx == 4) && (cap_q.size() == 4);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (first_low != 2) begin
         bad++; $display("FAIL b2b_ready_drop accepts_before_stall got %0d want 2", first_low);
      end
      total++;
      if (stable_checks < 3) begin
         bad++; $display("FAIL b2b_stall_len stalled_cycles got %0d want 3", stable_checks);
      end
      total++;
      if (cap_q.size() != 4) begin
         bad++; $display("FAIL b2b_count got %0d beats want 4", cap_q.size());
      end
      for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
         total++;
         if (cap_q[i] !== {1'b0, words[i]}) begin
            bad++; $display("FAIL b2b_word%0d got %h want %h", i, cap_q[i], {1'b0, words[i]});
         end
      end
      total++;
      if (err_count_a !== 2'(exp_cnt_a)) begin
         bad++; $display("FAIL b2b_cnt got %0d want %0d", err_count_a, exp_cnt_a);
      end
   endtask

   task automatic test_random(input int s);
      logic acc, e;
      logic [31:0] imm;
      encoding_type enc;
      sel = (s == 1); cap_q.delete(); exp_q.delete();
      in_valid = 1'b0; acc = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || acc) begin
            if ($urandom_range(0, 3) != 0) begin
               enc = encoding_type'(3'($urandom_range(0, 5)));
               case ($urandom_range(0, 3))
                  0:       imm = $urandom;
                  1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                  2:       imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                  default: imm = $urandom & 32'hFFFFF000;
               endcase
               set_fields(enc, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                          5'($urandom), 7'($urandom), imm);
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && in_ready_m;
         if (acc) begin
            e = ref_err(in_encoding, in_imm);
            if (e) begin
               if (s == 0) exp_cnt_a = (exp_cnt_a < 3) ? exp_cnt_a + 1 : 3;
               else        exp_cnt_b = (exp_cnt_b < 65535) ? exp_cnt_b + 1 : 65535;
            end
            if (!(s == 0 && e))
               exp_q.push_back({e, ref_word(in_encoding, in_opcode, in_rd, in_funct3,
                                            in_rs1, in_rs2, in_funct7, in_imm)});
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && cap_q.size() < exp_q.size(); k++) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (cap_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rnd_s%0d_count got %0d beats want %0d", s, cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++;
         if (cap_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL rnd_s%0d_beat%0d got %h want %h", s, i, cap_q[i], exp_q[i]);
         end
      end
      total++;
      if (err_count_m !== 16'((s == 0) ? exp_cnt_a : exp_cnt_b)) begin
         bad++; $display("FAIL rnd_s%0d_cnt got %0d want %0d", s, err_count_m,
                         (s == 0) ? exp_cnt_a : exp_cnt_b);
      end
   endtask

   task automatic test_counter();
      sel = 1'b0; out_ready = 1'b1; cap_q.delete();
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      exp_cnt_a = 0;
      total++;
      if (err_count_a !== 2'd0) begin bad++; $display("FAIL cnt_clear got %0d want 0", err_count_a); end
      for (int i = 1; i <= 5; i++) begin
         send(ENC_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
         @(negedge clk);
         @(negedge clk);
         total++;
         if (err_count_a !== 2'((i < 3) ? i : 3)) begin
            bad++; $display("FAIL cnt_sat%0d got %0d want %0d", i, err_count_a, (i < 3) ? i : 3);
         end
         @(posedge clk); #1;
      end
      send(ENC_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      @(negedge clk);
      total++;
      if (err_count_a !== 2'd0) begin bad++; $display("FAIL cnt_clear_prio got %0d want 0", err_count_a); end
      total++;
      if (cap_q.size() != 0) begin bad++; $display("FAIL cnt_no_beats got %0d beats want 0", cap_q.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midstream();
      sel = 1'b1; out_ready = 1'b0;
      send(ENC_I, 7'h13, 5'd4, 3'd0, 5'd1, 5'd0, 7'd0, 32'd100);
      send(ENC_I, 7'h13, 5'd5, 3'd0, 5'd1, 5'd0, 7'd0, 32'd200);
      @(negedge clk);
      total++;
      if (out_valid_b !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got %b want 1", out_valid_b); end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (out_valid_b !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", out_valid_b); end
      total++;
      if (err_count_b !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got %0d want 0", err_count_b); end
      exp_cnt_a = 0; exp_cnt_b = 0;
      @(posedge clk); #1;
      reset_n = 1'b1; out_ready = 1'b1; cap_q.delete();
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (cap_q.size() != 0 || out_valid_b !== 1'b0) begin
         bad++; $display("FAIL mid_dropped got %0d stale beats valid=%b want 0 beats valid=0",
                         cap_q.size(), out_valid_b);
      end
      total++;
      if (in_ready_b !== 1'b1) begin bad++; $display("FAIL mid_ready got %b want 1", in_ready_b); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_boundaries();
      test_back_to_back();
      test_random(0);
      test_random(1);
      test_counter();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
